// File: rtl/csa_word_seq.sv
// csa_word_seq
// Sequences a wide add through an external, purely combinational 8-bit
// carry-select adder, one byte slice per clock, least significant slice first.
// The slice carry is chained through carry_reg and every slice sum is
// captured into the registered result.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start                 operation request, accepted only in IDLE
//   a, b, c_in            operands and carry-in, latched when start is accepted
//   busy                  high while slices are being processed (RUN)
//   done                  one-cycle pulse when sum/c_out/zero are valid
//   sum, c_out, zero      registered W-bit result, final carry, sum==0 flag
//   slice_a, slice_b      byte slice driven to the external adder
//   slice_cin             chained carry driven to the external adder
//   slice_sum, slice_cout result returned by the external adder
module csa_word_seq #(
   parameter int WORDS = 4,
   localparam int W    = 8 * WORDS,
   localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         c_out,
   output logic         zero,
   output logic [7:0]   slice_a,
   output logic [7:0]   slice_b,
   output logic         slice_cin,
   input  logic [7:0]   slice_sum,
   input  logic         slice_cout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic           carry_reg;
   logic [IW-1:0]  idx;
   logic [W-1:0]   sum_next;
   logic           last_slice;

   assign last_slice = (idx == IW'(WORDS - 1));

   // busy and done are pure state decodes, so no path exists from the
   // external adder to any handshake output.
   assign busy = (state == RUN);
   assign done = (state == DONE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: DONE always lasts exactly one cycle, and start is
   // only looked at in IDLE, so requests during RUN/DONE are dropped.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN:  if (last_slice) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Slice multiplexer towards the adder; driven to zero outside RUN so the
   // adder inputs are quiet between operations.
   always_comb begin
      slice_a   = '0;
      slice_b   = '0;
      slice_cin = 1'b0;
      if (state == RUN) begin
         slice_cin = carry_reg;
         for (int i = 0; i < WORDS; i++) begin
            if (idx == IW'(i)) begin
               slice_a = a_reg[8*i +: 8];
               slice_b = b_reg[8*i +: 8];
            end
         end
      end
   end

   // Running result with the current slice merged in. The zero flag is taken
   // from this value so the final slice is included in the test.
   always_comb begin
      sum_next = sum;
      for (int i = 0; i < WORDS; i++) begin
         if (idx == IW'(i)) begin
            sum_next[8*i +: 8] = slice_sum;
         end
      end
   end

   // Datapath: operand capture on accepted start, slice accumulation and
   // carry chaining during RUN, final carry and zero flag on the last slice.
   // The previous result stays visible in IDLE until the next start clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         idx       <= '0;
         sum       <= '0;
         c_out     <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  carry_reg <= c_in;
                  idx       <= '0;
                  sum       <= '0;
                  c_out     <= 1'b0;
                  zero      <= 1'b0;
               end
            end
            RUN: begin
               sum       <= sum_next;
               carry_reg <= slice_cout;
               if (last_slice) begin
                  c_out <= slice_cout;
                  zero  <= (sum_next == '0);
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_word_seq.sv
// tb_csa_word_seq
// Self-checking bench for csa_word_seq. A 4-slice instance and a 1-slice
// instance are each wired to a behavioural 8-bit adder standing in for the
// external carry-select adder. Expected results come from a plain wide
// addition a + b + c_in.
module tb_csa_word_seq;

   logic        clk;
   logic        rst;

   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        c_in;
   logic        busy;
   logic        done;
   logic [31:0] sum;
   logic        c_out;
   logic        zero;
   logic [7:0]  slice_a;
   logic [7:0]  slice_b;
   logic        slice_cin;
   logic [7:0]  slice_sum;
   logic        slice_cout;

   logic        start1;
   logic [7:0]  a1;
   logic [7:0]  b1;
   logic        c_in1;
   logic        busy1;
   logic        done1;
   logic [7:0]  sum1;
   logic        c_out1;
   logic        zero1;
   logic [7:0]  slice_a1;
   logic [7:0]  slice_b1;
   logic        slice_cin1;
   logic [7:0]  slice_sum1;
   logic        slice_cout1;

   int errors;
   int checks;

   csa_word_seq #(.WORDS(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
      .busy(busy), .done(done), .sum(sum), .c_out(c_out), .zero(zero),
      .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
      .slice_sum(slice_sum), .slice_cout(slice_cout)
   );

   csa_word_seq #(.WORDS(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(c_in1),
      .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1), .zero(zero1),
      .slice_a(slice_a1), .slice_b(slice_b1), .slice_cin(slice_cin1),
      .slice_sum(slice_sum1), .slice_cout(slice_cout1)
   );

   // Behavioural stand-ins for the external 8-bit adder.
   assign {slice_cout, slice_sum}   = {1'b0, slice_a}  + {1'b0, slice_b}  + {8'd0, slice_cin};
   assign {slice_cout1, slice_sum1} = {1'b0, slice_a1} + {1'b0, slice_b1} + {8'd0, slice_cin1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one operation on the 4-slice instance and returns what was seen.
   // Operands are scrambled after acceptance to prove only latched copies
   // are used. A missing done pulse is reported as a failed check.
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                         output logic [31:0] s, output logic co, output logic z,
                         output int busy_n, output logic [7:0] cin_seq, output int done_n);
      a = av; b = bv; c_in = cv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom; c_in = 1'($urandom);
      busy_n = 0; cin_seq = '0; done_n = 0;
      for (int k = 0; k < 20 && done !== 1'b1; k++) begin
         if (busy === 1'b1) begin
            if (busy_n < 8) cin_seq[busy_n[2:0]] = slice_cin;
            busy_n++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL done_timeout: done=%b required 1", done);
      end else begin
         done_n = 1;
      end
      s = sum; co = c_out; z = zero;
      @(posedge clk); #1;
      if (done === 1'b1) done_n++;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, sum, c_out, zero, slice_a, slice_b, slice_cin} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: busy=%b done=%b sum=%h c_out=%b zero=%b sa=%h sb=%h scin=%b required all 0",
                  busy, done, sum, c_out, zero, slice_a, slice_b, slice_cin);
      end
      checks++;
      if ({busy1, done1, sum1, c_out1, zero1, slice_a1, slice_b1, slice_cin1} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs_w1: busy=%b done=%b sum=%h c_out=%b zero=%b required all 0",
                  busy1, done1, sum1, c_out1, zero1);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, slice_a, slice_b, slice_cin} !== '0) begin
         errors++;
         $display("[TB] FAIL idle_quiet: busy=%b done=%b sa=%h sb=%h scin=%b required all 0",
                  busy, done, slice_a, slice_b, slice_cin);
      end
   endtask

   task automatic test_directed();
      logic [31:0] s;
      logic        co, z;
      int          bn, dn;
      logic [7:0]  cs;

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, s, co, z, bn, cs, dn);
      checks++;
      if ({s, co, z} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL all_ones: sum=%h c_out=%b zero=%b required FFFFFFFF 1 0", s, co, z);
      end
      checks++;
      if (bn !== 4 || cs !== 8'b0000_1111) begin
         errors++;
         $display("[TB] FAIL all_ones_run: busy_cycles=%0d cin_seq=%b required 4 00001111", bn, cs);
      end

      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, s, co, z, bn, cs, dn);
      checks++;
      if ({s, co, z} !== {32'h0000_0100, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL carry_chain: sum=%h c_out=%b zero=%b required 00000100 0 0", s, co, z);
      end
      checks++;
      if (cs !== 8'b0000_0010) begin
         errors++;
         $display("[TB] FAIL carry_chain_cin: cin_seq=%b required 00000010", cs);
      end

      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, s, co, z, bn, cs, dn);
      checks++;
      if ({s, co, z} !== {32'h0000_0000, 1'b1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL wrap_zero: sum=%h c_out=%b zero=%b required 00000000 1 1", s, co, z);
      end
      checks++;
      if (dn !== 1) begin
         errors++;
         $display("[TB] FAIL wrap_zero_done: done_pulses=%0d required 1", dn);
      end
   endtask

   task automatic test_random();
      logic [31:0] av, bv, s;
      logic        cv, co, z;
      logic [32:0] ref_full;
      int          bn, dn;
      logic [7:0]  cs;
      for (int n = 0; n < 24; n++) begin
         av = $urandom; bv = $urandom; cv = 1'($urandom);
         if (n % 6 == 0) bv = -av - 32'(cv);
         ref_full = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
         run_op(av, bv, cv, s, co, z, bn, cs, dn);
         checks++;
         if ({s, co, z} !== {ref_full[31:0], ref_full[32], ref_full[31:0] == 32'd0}) begin
            errors++;
            $display("[TB] FAIL random_add a=%h b=%h cin=%b: sum=%h c_out=%b zero=%b required %h %b %b",
                     av, bv, cv, s, co, z, ref_full[31:0], ref_full[32], ref_full[31:0] == 32'd0);
         end
         checks++;
         if (bn !== 4 || dn !== 1) begin
            errors++;
            $display("[TB] FAIL random_timing: busy_cycles=%0d done_pulses=%0d required 4 1", bn, dn);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bn;
      a = 32'd1; b = 32'd2; c_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 32'h10; b = 32'h20;
      bn = 0;
      for (int k = 0; k < 20 && done !== 1'b1; k++) begin
         if (busy === 1'b1) bn++;
         @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1 || sum !== 32'h3 || bn !== 4) begin
         errors++;
         $display("[TB] FAIL start_ignored: done=%b sum=%h busy_cycles=%0d required 1 00000003 4", done, sum, bn);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 32'h3) begin
         errors++;
         $display("[TB] FAIL idle_after_done: busy=%b done=%b sum=%h required 0 0 00000003", busy, done, sum);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL held_start_accept: busy=%b required 1", busy);
      end
      for (int k = 0; k < 20 && done !== 1'b1; k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1 || sum !== 32'h30 || c_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL held_start_result: done=%b sum=%h c_out=%b required 1 00000030 0", done, sum, c_out);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] s;
      logic        co, z;
      int          bn, dn, seen;
      logic [7:0]  cs;
      a = 32'h1234_5678; b = 32'h1111_1111; c_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, sum, c_out, zero, slice_a, slice_b, slice_cin} !== '0) begin
         errors++;
         $display("[TB] FAIL mid_run_reset: busy=%b done=%b sum=%h c_out=%b zero=%b sa=%h sb=%h scin=%b required all 0",
                  busy, done, sum, c_out, zero, slice_a, slice_b, slice_cin);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("[TB] FAIL no_done_after_reset: active_cycles=%0d required 0", seen);
      end
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, s, co, z, bn, cs, dn);
      checks++;
      if ({s, co, z} !== {32'h2345_6789, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL restart_after_reset: sum=%h c_out=%b zero=%b required 23456789 0 0", s, co, z);
      end
   endtask

   task automatic test_single_slice();
      a1 = 8'hFF; b1 = 8'hFF; c_in1 = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = 8'h00; b1 = 8'h00; c_in1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0 || slice_cin1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL w1_run: busy=%b done=%b slice_cin=%b required 1 0 1", busy1, done1, slice_cin1);
      end
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 8'hFF || c_out1 !== 1'b1 || zero1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL w1_result: done=%b busy=%b sum=%h c_out=%b zero=%b required 1 0 FF 1 0",
                  done1, busy1, sum1, c_out1, zero1);
      end
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL w1_done_pulse: done=%b required 0", done1);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      test_single_slice();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/csa_word_seq.md
Name: csa_word_seq

Overview:
Multi-slice sequencer that sits directly upstream and downstream of the 8-bit carry-select adder (z_n_csa).
- Latches a wide operand pair and feeds the external 8-bit CSA one byte slice per clock, LSB slice first.
- Chains the slice carry through a register and captures each slice sum.
- Presents the full-width sum, carry-out and zero flag with a start/busy/done handshake.
- The CSA instance stays purely combinational; this block owns all sequencing.

Parameters:
- WORDS, 4, number of 8-bit slices; operand width W = 8*WORDS; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high; one clock, no other clock or reset domains.
- start  in  1  request; sampled only in IDLE.
- a  in  W  operand A; sampled on accepted start.
- b  in  W  operand B; sampled on accepted start.
- c_in  in  1  carry-in; sampled on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse when the result is valid.
- sum  out  W  registered result.
- c_out  out  1  registered final carry.
- zero  out  1  registered flag, high when sum == 0.
- slice_a  out  8  to CSA a.
- slice_b  out  8  to CSA b.
- slice_cin  out  1  to CSA c_in.
- slice_sum  in  8  from CSA sum.
- slice_cout  in  1  from CSA c_out.

Behaviour:
- Reset (async, immediate): state=IDLE, idx=0, carry_reg=0, operand regs=0. Outputs busy=0, done=0, sum=0, c_out=0, zero=0, slice_a=0, slice_b=0, slice_cin=0.
- States: IDLE, RUN, DONE. Slice index idx is ceil(log2(WORDS)) bits, minimum 1.
- IDLE:
  - If start=1 at an edge: latch a, b into a_reg, b_reg; carry_reg<=c_in; idx<=0; sum<=0; c_out<=0; zero<=0; go to RUN.
  - Otherwise hold. Previous result stays on sum, c_out and zero.
- RUN (busy=1):
  - Combinational drive: slice_a=a_reg[8*idx+:8], slice_b=b_reg[8*idx+:8], slice_cin=carry_reg.
  - Each edge: sum[8*idx+:8]<=slice_sum; carry_reg<=slice_cout; idx<=idx+1.
  - When idx==WORDS-1: c_out<=slice_cout; zero<=(completed sum==0), computed including the slice being written; go to DONE.
- DONE: done=1 for exactly one cycle; busy=0; unconditionally return to IDLE next edge.
- Slice drive outside RUN: slice_a, slice_b and slice_cin are 0 in IDLE and DONE.
- Latency: start accepted at edge E0, done high in the cycle after edge E_WORDS (WORDS+1 cycles from start to done inclusive). Throughput: one operation per WORDS+2 cycles.
- Start handling:
  - start is ignored in RUN and in DONE; there is no queueing.
  - A start held high through DONE is accepted at the first edge in IDLE.
- Operands: a, b and c_in may change freely after acceptance; only the latched copies are used.
- Arithmetic: unsigned modulo 2^W, with carry-out = bit W of a+b+c_in. Result equals a single W-bit add.
- WORDS=1: RUN lasts one edge, then DONE.
- Reset mid-RUN or mid-DONE: immediate return to the reset state. Partial sum cleared, done not pulsed.
- Outputs sum, c_out, zero, busy and done are registered or decoded from state only. No combinational path from slice_sum to any top-level output.

Test Plan:
1. WORDS=4, a=FFFFFFFF, b=FFFFFFFF, c_in=1, start pulsed -> busy high 4 cycles, then done 1 cycle with sum=FFFFFFFF, c_out=1, zero=0; slice_cin is 1 on all four RUN cycles.
2. a=000000FF, b=00000001, c_in=0 -> slice_cin sequence 0,1,0,0; sum=00000100, c_out=0, zero=0.
3. a=FFFFFFFF, b=00000001, c_in=0 -> sum=00000000, c_out=1, zero=1; done asserted exactly once.
4. Start a=1, b=2, then assert start with a=10, b=20 during RUN and DONE -> second request ignored, sum=00000003; holding start high through DONE launches a new op in the following IDLE cycle with latched a=10, b=20 -> sum=00000030.
5. Assert rst during the 2nd RUN cycle of a=12345678, b=11111111 -> all outputs 0 immediately, no done pulse; restarting the same op after reset -> sum=23456789, c_out=0.
6. WORDS=1 build, a=FF, b=FF, c_in=1 -> done two cycles after start with sum=FF, c_out=1, matching z_n_csa directly.
